lcd_timing_gen_param: RTL and testbench

- Parametrised LCD raster timing generator and test-pattern source; successor to the fixed 1056x525 timing controller.
- Generates HD/VD/DEN with configurable porches, sync widths and polarities.
- Either passes upstream pixels (request-driven) or generates one of several built-in patterns.
- Sits between the frame source/pixel pipeline and the LCD panel pins, in the LCD pixel-clock domain.

---
 rtl/lcd_tpg_pkg.sv | 29 ++
 rtl/lcd_sync_counter.sv | 64 ++++++
 rtl/lcd_timing_gen_param.sv | 202 ++++++++++++++++++++
 tb/tb_lcd_timing_gen_param.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_tpg_pkg.sv
// Shared definitions for the LCD timing generator / test-pattern source:
// display-mode encoding and the colour-bar table.
package lcd_tpg_pkg;

    typedef enum logic [2:0] {
        MODE_EXT    = 3'd0,
        MODE_GRAY   = 3'd1,
        MODE_RGB    = 3'd2,
        MODE_BARS   = 3'd3,
        MODE_WHITE  = 3'd4,
        MODE_GRAY50 = 3'd5,
        MODE_CHECK  = 3'd6,
        MODE_BORDER = 3'd7
    } mode_e;

    localparam int N_BARS = 8;

    // One {R,G,B} on/off triple per bar, bar 0 in the low bits:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [3*N_BARS-1:0] BAR_TABLE = {
        3'b000, 3'b001, 3'b100, 3'b101,
        3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        return BAR_TABLE[3*idx +: 3];
    endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// Raster counters for the LCD timing generator: h/v position, active-area
// request with active-relative X/Y, and sync levels (all combinational on the counters).
module lcd_sync_counter #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 34,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    output logic        oREQ,
    output logic [10:0] oX,
    output logic [9:0]  oY,
    output logic        oHS,
    output logic        oVS,
    output logic        oFRAME_START
);
    localparam logic [10:0] H_TOT     = 11'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [10:0] H_ACT_BEG = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_END = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_SYNC_L  = 11'(H_SYNC);
    localparam logic [9:0]  V_TOT     = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [9:0]  V_ACT_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_ACT_END = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  V_SYNC_L  = 10'(V_SYNC);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        run;
    logic        h_act;
    logic        v_act;

    // Disable holds the raster at the origin so enabling always starts a fresh frame.
    always_ff @(posedge iCLK) begin
        if (iRST || !iEN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_TOT - 11'd1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_TOT - 10'd1) ? '0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign run   = iEN && !iRST;
    assign h_act = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    assign v_act = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);

    assign oREQ         = run && h_act && v_act;
    assign oX           = oREQ ? (h_cnt - H_ACT_BEG) : '0;
    assign oY           = oREQ ? (v_cnt - V_ACT_BEG) : '0;
    assign oHS          = (run && (h_cnt < H_SYNC_L)) ? HS_POL : ~HS_POL;
    assign oVS          = (run && (v_cnt < V_SYNC_L)) ? VS_POL : ~VS_POL;
    assign oFRAME_START = run && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/lcd_timing_gen_param.sv
// Parametrised LCD timing generator and test-pattern source (pass-through or built-in patterns).
// Define LCD_TPG_CHECKER_EN to build the checkerboard (mode 6) and bordered bars (mode 7).
module lcd_timing_gen_param
    import lcd_tpg_pkg::*;
#(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 215,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 1,
    parameter int V_BP     = 34,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 8
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iEN,
    input  logic [2:0]         iDISPLAY_MODE,
    input  logic [COLOR_W-1:0] iPIX_R,
    input  logic [COLOR_W-1:0] iPIX_G,
    input  logic [COLOR_W-1:0] iPIX_B,
    output logic               oREQ,
    output logic [10:0]        oX,
    output logic [9:0]         oY,
    output logic               oHD,
    output logic               oVD,
    output logic               oDEN,
    output logic [COLOR_W-1:0] oLCD_R,
    output logic [COLOR_W-1:0] oLCD_G,
    output logic [COLOR_W-1:0] oLCD_B,
    output logic               oSOF,
    output logic               oEOL
);
    localparam int                 BAR_W        = H_ACTIVE / N_BARS;
    localparam int                 BAR_CW       = $clog2(BAR_W + 1);
    localparam logic [BAR_CW-1:0]  BAR_LAST     = BAR_CW'(BAR_W - 1);
    localparam logic [10:0]        X_LAST       = 11'(H_ACTIVE - 1);
    localparam logic [9:0]         Y_THIRD      = 10'(V_ACTIVE / 3);
    localparam logic [9:0]         Y_TWO_THIRDS = 10'(2 * V_ACTIVE / 3);
    localparam logic [COLOR_W-1:0] C_FULL       = '1;
    localparam logic [COLOR_W-1:0] C_MID        = {1'b0, {(COLOR_W-1){1'b1}}};

    logic               vld_p0;
    logic               hs_p0;
    logic               vs_p0;
    logic               frame_start_p0;
    logic               sof_p0;
    logic               eol_p0;
    logic [10:0]        x_p0;
    logic [9:0]         y_p0;
    logic [COLOR_W-1:0] ramp_p0;
    logic [2:0]         bar_p0;
    logic [COLOR_W-1:0] r_p0;
    logic [COLOR_W-1:0] g_p0;
    logic [COLOR_W-1:0] b_p0;

    mode_e              mode_q;
    logic [BAR_CW-1:0]  bar_col;
    logic [2:0]         bar_idx;

    lcd_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL)
    ) u_sync (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iEN          (iEN),
        .oREQ         (vld_p0),
        .oX           (x_p0),
        .oY           (y_p0),
        .oHS          (hs_p0),
        .oVS          (vs_p0),
        .oFRAME_START (frame_start_p0)
    );

    assign oREQ   = vld_p0;
    assign oX     = x_p0;
    assign oY     = y_p0;
    assign sof_p0 = vld_p0 && (x_p0 == '0) && (y_p0 == '0);
    assign eol_p0 = vld_p0 && (x_p0 == X_LAST);

    // The raster origin is inside the sync region, so a mode loaded there
    // is in place before the first visible pixel of the frame.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            mode_q <= MODE_EXT;
        end else if (frame_start_p0) begin
            mode_q <= mode_e'(iDISPLAY_MODE);
        end
    end

    // Bar position tracks x_p0 without a divide; it returns to zero at every line end.
    always_ff @(posedge iCLK) begin
        if (iRST || !vld_p0) begin
            bar_col <= '0;
            bar_idx <= '0;
        end else if (bar_col == BAR_LAST) begin
            bar_col <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_col <= bar_col + BAR_CW'(1);
        end
    end

`ifdef LCD_TPG_CHECKER_EN
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
    logic border_p0;
    assign border_p0 = (x_p0 == '0) || (x_p0 == X_LAST) || (y_p0 == '0) || (y_p0 == Y_LAST);
`endif

    always_comb begin
        r_p0    = '0;
        g_p0    = '0;
        b_p0    = '0;
        ramp_p0 = x_p0[COLOR_W-1:0];
        bar_p0  = bar_rgb(bar_idx);
        case (mode_q)
            MODE_EXT: begin
                r_p0 = iPIX_R;
                g_p0 = iPIX_G;
                b_p0 = iPIX_B;
            end
            MODE_GRAY: begin
                r_p0 = ramp_p0;
                g_p0 = ramp_p0;
                b_p0 = ramp_p0;
            end
            MODE_RGB: begin
                if (y_p0 < Y_THIRD)           r_p0 = ramp_p0;
                else if (y_p0 < Y_TWO_THIRDS) g_p0 = ramp_p0;
                else                          b_p0 = ramp_p0;
            end
            MODE_BARS: begin
                r_p0 = {COLOR_W{bar_p0[2]}};
                g_p0 = {COLOR_W{bar_p0[1]}};
                b_p0 = {COLOR_W{bar_p0[0]}};
            end
            MODE_WHITE: begin
                r_p0 = C_FULL;
                g_p0 = C_FULL;
                b_p0 = C_FULL;
            end
            MODE_GRAY50: begin
                r_p0 = C_MID;
                g_p0 = C_MID;
                b_p0 = C_MID;
            end
`ifdef LCD_TPG_CHECKER_EN
            MODE_CHECK: begin
                r_p0 = {COLOR_W{x_p0[5] ^ y_p0[5]}};
                g_p0 = {COLOR_W{x_p0[5] ^ y_p0[5]}};
                b_p0 = {COLOR_W{x_p0[5] ^ y_p0[5]}};
            end
            MODE_BORDER: begin
                r_p0 = {COLOR_W{border_p0 | bar_p0[2]}};
                g_p0 = {COLOR_W{border_p0 | bar_p0[1]}};
                b_p0 = {COLOR_W{border_p0 | bar_p0[0]}};
            end
`endif
            default: begin
                r_p0 = '0;
                g_p0 = '0;
                b_p0 = '0;
            end
        endcase
    end

    // ---- stage 0 -> stage 1: all panel-side outputs registered together ----
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oDEN   <= 1'b0;
            oHD    <= ~HS_POL;
            oVD    <= ~VS_POL;
            oSOF   <= 1'b0;
            oEOL   <= 1'b0;
            oLCD_R <= '0;
            oLCD_G <= '0;
            oLCD_B <= '0;
        end else begin
            oDEN   <= vld_p0;
            oHD    <= hs_p0;
            oVD    <= vs_p0;
            oSOF   <= sof_p0;
            oEOL   <= eol_p0;
            oLCD_R <= vld_p0 ? r_p0 : '0;
            oLCD_G <= vld_p0 ? g_p0 : '0;
            oLCD_B <= vld_p0 ? b_p0 : '0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen_param.sv
// Randomised bench for lcd_timing_gen_param against a linear raster-position reference model.
module tb_lcd_timing_gen_param;
    localparam int HA = 64, HFP = 3, HS = 2, HBP = 5;
    localparam int VA = 40, VFP = 2, VS = 2, VBP = 3;
    localparam bit HSP = 1'b1, VSP = 1'b0;
    localparam int HT = HS + HBP + HA + HFP;
    localparam int VT = VS + VBP + VA + VFP;
    localparam int FRAME = HT * VT;
    localparam int HAB = HS + HBP;
    localparam int VAB = VS + VBP;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iEN;
    logic [2:0]  iDISPLAY_MODE;
    logic [7:0]  iPIX_R, iPIX_G, iPIX_B;
    logic        oREQ, oHD, oVD, oDEN, oSOF, oEOL;
    logic [10:0] oX;
    logic [9:0]  oY;
    logic [7:0]  oLCD_R, oLCD_G, oLCD_B;

    always #5 iCLK = ~iCLK;

    lcd_timing_gen_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(8)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iDISPLAY_MODE(iDISPLAY_MODE),
        .iPIX_R(iPIX_R), .iPIX_G(iPIX_G), .iPIX_B(iPIX_B),
        .oREQ(oREQ), .oX(oX), .oY(oY), .oHD(oHD), .oVD(oVD), .oDEN(oDEN),
        .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
        .oSOF(oSOF), .oEOL(oEOL)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: linear position in the frame since the raster (re)started.
    int         pos;
    int         frame_mode;
    logic [4:0] exp_ctl;
    logic [23:0] exp_rgb;
    int den_cnt, hd_cnt, vd_cnt, sof_cnt, eol_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] bars(input int x);
        case (x / (HA / 8))
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pattern(input int x, input int y, input int mode,
                                            input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        logic [7:0] ramp;
        ramp = 8'(x % 256);
        case (mode)
            0: return {r, g, b};
            1: return {ramp, ramp, ramp};
            2: begin
                if (y < VA / 3)          return {ramp, 16'h0};
                else if (y < 2 * VA / 3) return {8'h0, ramp, 8'h0};
                else                     return {16'h0, ramp};
            end
            3: return bars(x);
            4: return 24'hFFFFFF;
            5: return 24'h7F7F7F;
`ifdef LCD_TPG_CHECKER_EN
            6: return (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
            7: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 24'hFFFFFF : bars(x);
`endif
            default: return 24'h000000;
        endcase
    endfunction

    task automatic step(input logic en, input logic rst, input logic [2:0] mode);
        int h, v, x, y;
        logic run, act;
        logic [23:0] pix;
        iEN = en;
        iRST = rst;
        iDISPLAY_MODE = mode;
        iPIX_R = 8'($urandom);
        iPIX_G = 8'($urandom);
        iPIX_B = 8'($urandom);
        #1;
        run = en && !rst;
        h = pos % HT;
        v = pos / HT;
        act = run && h >= HAB && h < HAB + HA && v >= VAB && v < VAB + VA;
        x = act ? h - HAB : 0;
        y = act ? v - VAB : 0;
        check("req_xy", {42'd0, oREQ, oX, oY}, {42'd0, act, 11'(x), 10'(y)});
        check("ctl", {59'd0, oDEN, oHD, oVD, oSOF, oEOL}, {59'd0, exp_ctl});
        check("rgb", {40'd0, oLCD_R, oLCD_G, oLCD_B}, {40'd0, exp_rgb});
        den_cnt += int'(oDEN);
        hd_cnt  += int'(oHD == HSP);
        vd_cnt  += int'(oVD == VSP);
        sof_cnt += int'(oSOF);
        eol_cnt += int'(oEOL);
        pix = pattern(x, y, frame_mode, iPIX_R, iPIX_G, iPIX_B);
        exp_ctl = {act,
                   (run && h < HS) ? HSP : !HSP,
                   (run && v < VS) ? VSP : !VSP,
                   act && x == 0 && y == 0,
                   act && x == HA - 1};
        exp_rgb = act ? pix : 24'h0;
        if (rst) frame_mode = 0;
        else if (run && pos == 0) frame_mode = int'(mode);
        pos = run ? (pos + 1) % FRAME : 0;
        @(negedge iCLK);
    endtask

    task automatic run_mode(input int n, input logic [2:0] mode);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, mode);
    endtask

    initial begin
        int off;
        logic [2:0] m;
        iRST = 1'b1;
        iEN = 1'b0;
        iDISPLAY_MODE = 3'd0;
        iPIX_R = 8'h0;
        iPIX_G = 8'h0;
        iPIX_B = 8'h0;
        pos = 0;
        frame_mode = 0;
        exp_ctl = {1'b0, !HSP, !VSP, 2'b00};
        exp_rgb = 24'h0;
        den_cnt = 0; hd_cnt = 0; vd_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        repeat (2) @(negedge iCLK);

        repeat (3) step(1'b0, 1'b1, 3'd0);
        repeat (5) step(1'b0, 1'b0, 3'd4);

        // Solid white: one settling frame, then one frame of timing tallies.
        run_mode(FRAME, 3'd4);
        den_cnt = 0; hd_cnt = 0; vd_cnt = 0; sof_cnt = 0; eol_cnt = 0;
        run_mode(FRAME, 3'd4);
        check("den_per_frame", 64'(den_cnt), 64'(HA * VA));
        check("hd_active_clks", 64'(hd_cnt), 64'(HS * VT));
        check("vd_active_clks", 64'(vd_cnt), 64'(VS * HT));
        check("sof_per_frame", 64'(sof_cnt), 64'd1);
        check("eol_per_frame", 64'(eol_cnt), 64'(VA));

        run_mode(FRAME, 3'd0);
        run_mode(FRAME, 3'd3);

        // Gray ramp, switching to mid-gray part-way through the visible rows.
        run_mode(FRAME, 3'd1);
        run_mode((VAB + 20) * HT, 3'd1);
        run_mode(FRAME - (VAB + 20) * HT, 3'd5);
        run_mode(FRAME, 3'd5);

        run_mode(FRAME, 3'd6);
        run_mode(FRAME, 3'd7);
        run_mode(FRAME, 3'd2);

        // Reset pulse in the middle of a visible line.
        run_mode((VAB + 3) * HT + HAB + 10, 3'd3);
        step(1'b1, 1'b1, 3'd3);
        den_cnt = 0; sof_cnt = 0;
        run_mode(FRAME, 3'd3);
        check("sof_after_reset", 64'(sof_cnt), 64'd1);
        check("den_after_reset", 64'(den_cnt), 64'(HA * VA));

        // Random mode changes, enable drops and reset pulses.
        off = 0;
        m = 3'd3;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ($urandom_range(0, 499) == 0) m = 3'($urandom_range(0, 7));
            if (off == 0 && $urandom_range(0, 999) == 0) off = $urandom_range(1, 20);
            step(off == 0, $urandom_range(0, 1499) == 0, m);
            if (off > 0) off--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
